// File: rtl/rpi_word_assembler_pkg.sv
// Shared types and constants for the Raspberry Pi GPIO word assembler.
package rpi_word_assembler_pkg;

    localparam int BYTE_W             = 8;
    localparam int DEFAULT_WORD_BYTES = 8;
    localparam int CLK_HZ             = 100_000_000;

    // A partial word is abandoned after 1 ms without a new byte.
    localparam int DEFAULT_TIMEOUT_CYCLES = CLK_HZ / 1000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECV   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/rpi_word_assembler_if.sv
// Bus between the Raspberry Pi side and the word assembler, including the
// assembled-word outputs handed to the matrix stage.
interface rpi_word_assembler_if #(
    parameter int WORD_BYTES = rpi_word_assembler_pkg::DEFAULT_WORD_BYTES
);

    logic [rpi_word_assembler_pkg::BYTE_W-1:0]            rpi_data;
    logic                                                 rpi_strobe;
    logic                                                 rpi_frame;
    logic                                                 rpi_ack;
    logic [rpi_word_assembler_pkg::BYTE_W*WORD_BYTES-1:0] word_out;
    logic                                                 write_strobe;
    logic [2:0]                                           byte_count;
    logic                                                 timeout_err;

    // The Pi / environment side drives the GPIO pins and observes the results.
    modport master (
        output rpi_data, rpi_strobe, rpi_frame,
        input  rpi_ack, word_out, write_strobe, byte_count, timeout_err
    );

    // The assembler consumes the GPIO pins and produces the word outputs.
    modport slave (
        input  rpi_data, rpi_strobe, rpi_frame,
        output rpi_ack, word_out, write_strobe, byte_count, timeout_err
    );

endinterface

// File: rtl/rpi_word_assembler_sync_edge.sv
// Multi-flop synchroniser for one asynchronous control pin, with a
// rising-edge pulse derived from the synchronised level.
module rpi_word_assembler_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic sync_out,
    output logic rise
);

    logic [STAGES-1:0] chain;
    logic              delayed;
    logic [STAGES:0]   primed;

    // Synchroniser chain plus the one-cycle-late copy for edge detection; primed
    // fills with ones after reset so edges are reported only once both chain
    // and delayed copy hold real pin samples (a pin held high through reset is
    // then not mistaken for a fresh edge).
    always_ff @(posedge clk) begin
        if (reset) begin
            chain   <= '0;
            delayed <= 1'b0;
            primed  <= '0;
        end else begin
            chain   <= {chain[STAGES-2:0], async_in};
            delayed <= chain[STAGES-1];
            primed  <= {primed[STAGES-1:0], 1'b1};
        end
    end

    assign sync_out = chain[STAGES-1];
    assign rise     = sync_out & ~delayed & primed[STAGES];

endmodule

// File: rtl/rpi_word_assembler.sv
// Collects bytes strobed in from the Raspberry Pi GPIO bus into a word and
// hands each finished word to the output matrix stage with a write pulse.
module rpi_word_assembler
    import rpi_word_assembler_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int WORD_BYTES     = DEFAULT_WORD_BYTES,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                 clk_100mhz,
    input  logic                 reset,
    rpi_word_assembler_if.slave  bus
);

    localparam int               WORD_W     = BYTE_W * WORD_BYTES;
    localparam int               CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [2:0]       LAST_SLOT  = 3'(WORD_BYTES - 1);
    localparam logic [CNT_W-1:0] IDLE_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                             state;
    state_t                             next_state;
    logic                               strobe_rise;
    logic                               sync_frame;
    logic                               unused_strobe_level;
    logic                               unused_frame_rise;
    logic [SYNC_STAGES-1:0][BYTE_W-1:0] data_sync;
    logic [BYTE_W-1:0]                  sync_data;
    logic [WORD_W-1:0]                  assembled;
    logic [WORD_W-1:0]                  word_reg;
    logic [CNT_W-1:0]                   idle_count;
    logic [2:0]                         byte_count;
    logic                               ack;
    logic                               write_strobe;
    logic                               timeout_err;
    logic                               capture;
    logic                               commit;
    logic                               timeout_hit;

    rpi_word_assembler_sync_edge #(.STAGES(SYNC_STAGES)) strobe_sync (
        .clk      (clk_100mhz),
        .reset    (reset),
        .async_in (bus.rpi_strobe),
        .sync_out (unused_strobe_level),
        .rise     (strobe_rise)
    );

    rpi_word_assembler_sync_edge #(.STAGES(SYNC_STAGES)) frame_sync (
        .clk      (clk_100mhz),
        .reset    (reset),
        .async_in (bus.rpi_frame),
        .sync_out (sync_frame),
        .rise     (unused_frame_rise)
    );

    // Data goes through the same depth as the strobe so the rise cycle sees the matching byte.
    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            data_sync <= '0;
        end else begin
            data_sync <= {data_sync[SYNC_STAGES-2:0], bus.rpi_data};
        end
    end

    assign sync_data = data_sync[SYNC_STAGES-1];

    // FSM state register.
    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and datapath controls; frame loss beats a rise, a rise beats the timeout.
    always_comb begin
        next_state  = state;
        capture     = 1'b0;
        commit      = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            ST_IDLE: begin
                if (strobe_rise && sync_frame) begin
                    capture    = 1'b1;
                    next_state = ST_RECV;
                end
            end
            ST_RECV: begin
                if (!sync_frame) begin
                    next_state = ST_IDLE;
                end else if (strobe_rise) begin
                    capture = 1'b1;
                    if (byte_count == LAST_SLOT) begin
                        next_state = ST_COMMIT;
                    end
                end else if (idle_count == IDLE_LIMIT) begin
                    timeout_hit = 1'b1;
                    next_state  = ST_IDLE;
                end
            end
            ST_COMMIT: begin
                commit     = 1'b1;
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Byte slots, published word, ack toggle, byte counter, idle counter and the two pulses.
    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            assembled    <= '0;
            word_reg     <= '0;
            write_strobe <= 1'b0;
            timeout_err  <= 1'b0;
            ack          <= 1'b0;
            byte_count   <= '0;
            idle_count   <= '0;
        end else begin
            write_strobe <= commit;
            timeout_err  <= timeout_hit;
            if (capture) begin
                assembled[BYTE_W*int'(byte_count) +: BYTE_W] <= sync_data;
                ack <= ~ack;
            end
            if (commit) begin
                word_reg <= assembled;
            end
            if (next_state != ST_RECV) begin
                byte_count <= '0;
            end else if (capture) begin
                byte_count <= byte_count + 3'd1;
            end
            if (state != ST_RECV || strobe_rise) begin
                idle_count <= '0;
            end else begin
                idle_count <= idle_count + CNT_W'(1);
            end
        end
    end

    assign bus.rpi_ack      = ack;
    assign bus.word_out     = word_reg;
    assign bus.write_strobe = write_strobe;
    assign bus.byte_count   = byte_count;
    assign bus.timeout_err  = timeout_err;

endmodule
